// File: rtl/param_sync_fifo_if.sv
// Handshake and status bundle for param_sync_fifo; the slave modport is the FIFO side.
interface param_sync_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
);
  logic                  write_signal;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  read_signal;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_valid;
  logic                  data_permission;
  logic                  read_permission;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   fill_count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output write_signal, data_in, read_signal,
    input  data_out, data_valid, data_permission, read_permission,
    input  almost_full, almost_empty, fill_count, overflow, underflow
  );

  modport slave (
    input  write_signal, data_in, read_signal,
    output data_out, data_valid, data_permission, read_permission,
    output almost_full, almost_empty, fill_count, overflow, underflow
  );
endinterface

// File: rtl/param_sync_fifo.sv
// Single-clock FIFO with registered read data, fill-level flags and optional sticky
// overflow/underflow flags enabled by defining FIFO_ERR_FLAG_EN.
module param_sync_fifo #(
  parameter int DATA_WIDTH      = 8,
  parameter int ADDR_WIDTH      = 3,
  parameter int ALMOST_FULL_TH  = 6,
  parameter int ALMOST_EMPTY_TH = 1
) (
  input logic                clk,
  input logic                rst,
  param_sync_fifo_if.slave   bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int PW    = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wptr_q, wptr_d;
  logic [PW-1:0]         rptr_q, rptr_d;
  logic [PW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  data_valid_q, data_valid_d;
  logic                  full_s, empty_s, wr_en_s, rd_en_s;

  // Acceptance is decided from the registered count only, so full+both favours the
  // read and empty+both favours the write without any extra arbitration.
  always_comb begin
    full_s  = (count_q == PW'(DEPTH));
    empty_s = (count_q == '0);
    wr_en_s = bus.write_signal & ~full_s;
    rd_en_s = bus.read_signal & ~empty_s;
  end

  // Next-state for pointers, count and read data.
  always_comb begin
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    count_d      = count_q;
    data_out_d   = data_out_q;
    data_valid_d = rd_en_s;
    if (wr_en_s) begin
      wptr_d = wptr_q + PW'(1);
    end else begin
      wptr_d = wptr_q;
    end
    if (rd_en_s) begin
      rptr_d     = rptr_q + PW'(1);
      data_out_d = mem[rptr_q[ADDR_WIDTH-1:0]];
    end else begin
      rptr_d     = rptr_q;
      data_out_d = data_out_q;
    end
    case ({wr_en_s, rd_en_s})
      2'b10:   count_d = count_q + PW'(1);
      2'b01:   count_d = count_q - PW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
    end else begin
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      count_q      <= count_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
    end
  end

  // Storage array; contents survive reset but become unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (!rst && wr_en_s) begin
      mem[wptr_q[ADDR_WIDTH-1:0]] <= bus.data_in;
    end
  end

`ifdef FIFO_ERR_FLAG_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  // Rejected requests latch their error flag until reset.
  always_comb begin
    overflow_d  = overflow_q  | (bus.write_signal & full_s);
    underflow_d = underflow_q | (bus.read_signal & empty_s);
  end

  // Sticky error flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
`else
  assign bus.overflow  = 1'b0;
  assign bus.underflow = 1'b0;
`endif

  assign bus.data_out        = data_out_q;
  assign bus.data_valid      = data_valid_q;
  assign bus.fill_count      = count_q;
  assign bus.data_permission = ~full_s;
  assign bus.read_permission = ~empty_s;
  assign bus.almost_full     = (count_q >= PW'(ALMOST_FULL_TH));
  assign bus.almost_empty    = (count_q <= PW'(ALMOST_EMPTY_TH));
endmodule

// File: doc/param_sync_fifo.md
PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 3, log2 of depth; DEPTH = 2**ADDR_WIDTH.
REQ-003 SHALL have parameter ALMOST_FULL_TH, default 6, fill level at or above which almost_full asserts.
REQ-004 SHALL have parameter ALMOST_EMPTY_TH, default 1, fill level at or below which almost_empty asserts.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port write_signal  input  1  write request.
REQ-008 SHALL have port data_in  input  DATA_WIDTH  write data.
REQ-009 SHALL have port read_signal  input  1  read request.
REQ-010 SHALL have port data_out  output  DATA_WIDTH  registered read data.
REQ-011 SHALL have port data_valid  output  1  data_out updated by a read this cycle.
REQ-012 SHALL have port data_permission  output  1  not full; write accepted.
REQ-013 SHALL have port read_permission  output  1  not empty; read accepted.
REQ-014 SHALL have port almost_full  output  1  fill_count >= ALMOST_FULL_TH.
REQ-015 SHALL have port almost_empty  output  1  fill_count <= ALMOST_EMPTY_TH.
REQ-016 SHALL have port fill_count  output  ADDR_WIDTH+1  stored word count, 0..DEPTH.
REQ-017 SHALL have ports overflow, underflow  output  1 each  sticky error flags (see Configuration).

Function
REQ-018 SHALL store words in a DEPTH x DATA_WIDTH array addressed by ADDR_WIDTH+1-bit write/read pointers whose low ADDR_WIDTH bits index the array, wrapping modulo 2*DEPTH.
REQ-019 SHALL accept a write when write_signal && data_permission: mem[wptr] <= data_in, wptr increments.
REQ-020 SHALL accept a read when read_signal && read_permission: data_out <= mem[rptr] on that edge, rptr increments, data_valid = 1 for the following cycle only.
REQ-021 SHALL hold data_out when no read is accepted, data_valid = 0 that cycle.
REQ-022 SHALL update fill_count: +1 write only, -1 read only, unchanged for both or neither.
REQ-023 SHALL derive all flags from the current registered fill_count: data_permission = (count != DEPTH), read_permission = (count != 0).
REQ-024 SHALL, when full with simultaneous write and read, accept the read and reject the write; count -> DEPTH-1.
REQ-025 SHALL, when empty with simultaneous write and read, accept the write and reject the read; count -> 1, data_valid stays 0.
REQ-026 SHALL, with simultaneous accepted write and read when 0 < count < DEPTH, perform both with count unchanged (write-to-read latency 2 cycles minimum).
REQ-027 SHALL preserve FIFO order across pointer wrap-around.

Reset
REQ-028 SHALL, on rst high at a clock edge, clear pointers, fill_count, data_out to 0, data_valid 0, overflow/underflow 0.
REQ-029 SHALL give post-reset flags data_permission 1, read_permission 0, almost_empty 1, almost_full 0.
REQ-030 SHALL let rst take priority over simultaneous write/read; memory contents are not cleared but become unreachable.

Configuration
REQ-031 SHALL, with FIFO_ERR_FLAG_EN defined, set overflow on write_signal && !data_permission and underflow on read_signal && !read_permission, each sticky until rst.
REQ-032 SHALL, without FIFO_ERR_FLAG_EN, drive overflow and underflow constant 0 with no error logic; port list unchanged.

Verification (DATA_WIDTH=8, ADDR_WIDTH=3, AF_TH=6, AE_TH=1)
REQ-033 SHALL cover: write 0x01..0x08 -> count 8, data_permission 0, almost_full 1 after 6th write; read 8 -> data_out 0x01..0x08 in order, data_valid each.
REQ-034 SHALL cover: full FIFO, write 0xAA + read same cycle -> data_out 0x01, count 7, 0xAA absent; with FIFO_ERR_FLAG_EN overflow = 1.
REQ-035 SHALL cover: empty FIFO, write 0x55 + read same cycle -> data_valid 0, count 1; next-cycle read -> data_out 0x55.
REQ-036 SHALL cover: 20 writes interleaved with reads keeping count 3..5 -> correct order across pointer wrap, count never off.
REQ-037 SHALL cover: rst asserted with count 5 mid-write -> next cycle count 0, read_permission 0, data_valid 0, errors 0.
REQ-038 SHALL cover: read on empty -> data_out held, underflow = 1 if FIFO_ERR_FLAG_EN, else 0.
